controle_injecao: RTL and testbench
===================================

# controle_injecao

Sequencer for the 15-bit single-bit error injector in the Hamming (15,11) test path. On `start` it runs a 16-pass fault-injection campaign over one golden codeword. Passes 0-14 flip bit `n = pass`; pass 15 is clean. For each pass it hands the injected word to the downstream decoder over a req/ack handshake, compares the decoder's corrected word against the golden codeword, and accumulates pass/fail statistics. It sits between the test stimulus source, the injector and the decoder, and owns the injector's `entrada`, `n` and `erro` inputs.

## Interface
- `TIMEOUT`, 8: max cycles `req_dec` stays high waiting for `ack_dec` before the pass is declared failed (2..255).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  campaign start; honoured only in IDLE.
- `codigo`  in  15  golden codeword; sampled into `codigo_reg` on accepted `start`.
- `entrada_inj`  out  15  to injector `entrada`; equals `codigo_reg`.
- `n_inj`  out  4  to injector `n`.
- `erro_inj`  out  1  to injector `erro`.
- `req_dec`  out  1  decoder request; the injected word is valid while high.
- `ack_dec`  in  1  decoder acknowledge; `corrigido` is valid in the same cycle.
- `corrigido`  in  15  decoder corrected codeword.
- `busy`  out  1  high from the cycle after an accepted `start` through FIM.
- `done`  out  1  one-cycle pulse in FIM.
- `falhas`  out  5  count of failed passes (0..16).
- `primeira_falha`  out  5  index of the first failed pass; 5'd31 = none.
- `timeout_flag`  out  1  sticky; set if any pass timed out.

## Operation
- States: IDLE, ESPERA, AVALIA, FIM. All outputs are registered.
- Reset values: state IDLE, `codigo_reg`/`entrada_inj` 0, `n_inj` 0, `erro_inj` 0, `req_dec` 0, `busy` 0, `done` 0, `falhas` 0, `primeira_falha` 31, `timeout_flag` 0, pass index `idx` 0, timeout counter 0.
- IDLE + `start`:
  - Latch `codigo`.
  - Clear `falhas`, `primeira_falha` (to 31), `timeout_flag`; `idx`=0.
  - Go to ESPERA.
- ESPERA:
  - `req_dec`=1; `n_inj` = `idx`[3:0] for `idx` ≤ 14, else 0; `erro_inj` = (`idx` ≤ 14).
  - Drive values stay stable for the whole state.
  - The timeout counter increments each cycle in ESPERA.
- ESPERA exit on `ack_dec`=1: capture `corrigido`, set pass result = (`corrigido` ≠ `codigo_reg`), go to AVALIA.
- ESPERA exit on timeout (counter = `TIMEOUT`−1 with no ack): pass result = fail, set `timeout_flag`, go to AVALIA.
- AVALIA:
  - `req_dec`=0; counter cleared.
  - On fail: `falhas`+1; if `primeira_falha`=31, load `idx`.
  - If `idx`=15, go to FIM; else `idx`+1 and go to ESPERA.
- FIM: `done`=1 for one cycle, `busy`=0 next cycle, return to IDLE.
- Results hold until the next accepted `start`.
- `start` outside IDLE is ignored.
- `ack_dec` outside ESPERA is ignored.
- `falhas` cannot overflow: max 16 fits in 5 bits.
- Async reset mid-campaign returns immediately to the reset values; no `done` is generated.

## Timing
- Pass duration is (k+1) ESPERA cycles + 1 AVALIA cycle, where k = cycles until ack (k=0: ack in the first ESPERA cycle).
- With a timeout, the pass lasts `TIMEOUT` + 1 cycles.
- `start` sampled at edge E0: first ESPERA cycle is E0+1.
- With a zero-latency ack, `done` is high at cycle E0+33; `busy` is high E0+1..E0+33.
- `req_dec` falls on the edge after ack is sampled. The decoder must not assert a second ack for the same request.
- Injector outputs change only on ESPERA entry. The decoder sees a stable word for the full request.

## Test plan
- `codigo`=15'h0000, ideal correcting decoder model, ack same cycle -> `falhas`=0, `primeira_falha`=31, `timeout_flag`=0, `done` at E0+33.
- `codigo`=15'h5A5A, decoder passes the word through uncorrected -> `falhas`=15, `primeira_falha`=0; the clean pass (idx 15) passes.
- Decoder never acks, `TIMEOUT`=8 -> each pass 9 cycles, `falhas`=16, `primeira_falha`=0, `timeout_flag`=1, `done` at E0+145.
- Ideal decoder except it miscorrects only `n`=7, ack latency 3 -> `falhas`=1, `primeira_falha`=7, each pass 5 cycles.
- `start` re-pulsed at idx 5 and `rst_n` dropped at idx 9 of a second run -> the first pulse is ignored; after reset all outputs return to reset values, no `done`; a new `start` runs a full campaign.
- `ack_dec` held high in AVALIA/IDLE -> no extra captures, `falhas` unchanged.

Source files
------------

// File: rtl/controle_injecao.sv
// Sequencer for a 16-pass single-bit fault-injection campaign over a Hamming (15,11) codeword.
// Drives the injector, handshakes each injected word with the decoder and accumulates pass/fail statistics.
module controle_injecao #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [14:0] codigo,
    output logic [14:0] entrada_inj,
    output logic [3:0]  n_inj,
    output logic        erro_inj,
    output logic        req_dec,
    input  logic        ack_dec,
    input  logic [14:0] corrigido,
    output logic        busy,
    output logic        done,
    output logic [4:0]  falhas,
    output logic [4:0]  primeira_falha,
    output logic        timeout_flag
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ESPERA = 2'd1;
    localparam logic [1:0] AVALIA = 2'd2;
    localparam logic [1:0] FIM    = 2'd3;

    localparam logic [7:0] LIMITE      = 8'(TIMEOUT - 1);
    localparam logic [4:0] SEM_FALHA   = 5'd31;
    localparam logic [3:0] PASSE_LIMPO = 4'd15;

    logic [1:0]  state;
    logic [14:0] codigo_reg;
    logic [3:0]  idx;
    logic [3:0]  idx_next;
    logic [7:0]  contador;
    logic        falha_pass;

    assign entrada_inj = codigo_reg;
    assign idx_next    = idx + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            codigo_reg     <= 15'd0;
            idx            <= 4'd0;
            contador       <= 8'd0;
            falha_pass     <= 1'b0;
            n_inj          <= 4'd0;
            erro_inj       <= 1'b0;
            req_dec        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            falhas         <= 5'd0;
            primeira_falha <= SEM_FALHA;
            timeout_flag   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        codigo_reg     <= codigo;
                        falhas         <= 5'd0;
                        primeira_falha <= SEM_FALHA;
                        timeout_flag   <= 1'b0;
                        idx            <= 4'd0;
                        contador       <= 8'd0;
                        n_inj          <= 4'd0;
                        erro_inj       <= 1'b1;
                        req_dec        <= 1'b1;
                        busy           <= 1'b1;
                        state          <= ESPERA;
                    end
                end
                ESPERA: begin
                    contador <= contador + 8'd1;
                    // An ack arriving on the last allowed cycle still counts as a real response.
                    if (ack_dec) begin
                        falha_pass <= (corrigido != codigo_reg);
                        req_dec    <= 1'b0;
                        state      <= AVALIA;
                    end else if (contador == LIMITE) begin
                        falha_pass   <= 1'b1;
                        timeout_flag <= 1'b1;
                        req_dec      <= 1'b0;
                        state        <= AVALIA;
                    end
                end
                AVALIA: begin
                    contador <= 8'd0;
                    if (falha_pass) begin
                        falhas <= falhas + 5'd1;
                        if (primeira_falha == SEM_FALHA) begin
                            primeira_falha <= {1'b0, idx};
                        end
                    end
                    if (idx == PASSE_LIMPO) begin
                        done  <= 1'b1;
                        state <= FIM;
                    end else begin
                        // Injector drive only changes here, on entry to the next request.
                        idx      <= idx_next;
                        n_inj    <= (idx_next == PASSE_LIMPO) ? 4'd0 : idx_next;
                        erro_inj <= (idx_next != PASSE_LIMPO);
                        req_dec  <= 1'b1;
                        state    <= ESPERA;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controle_injecao.sv
// Bench for controle_injecao: a behavioural decoder answers each request while a scoreboard
// checks the injector drive per pass and the campaign statistics at done.
module tb_controle_injecao;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [14:0] codigo;
    logic [14:0] entrada_inj;
    logic [3:0]  n_inj;
    logic        erro_inj;
    logic        req_dec;
    logic        ack_dec;
    logic [14:0] corrigido;
    logic        busy;
    logic        done;
    logic [4:0]  falhas;
    logic [4:0]  primeira_falha;
    logic        timeout_flag;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct packed {
        logic [3:0]  n;
        logic        erro;
        logic [14:0] word;
    } exp_t;

    exp_t sb[$];

    controle_injecao #(.TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .codigo         (codigo),
        .entrada_inj    (entrada_inj),
        .n_inj          (n_inj),
        .erro_inj       (erro_inj),
        .req_dec        (req_dec),
        .ack_dec        (ack_dec),
        .corrigido      (corrigido),
        .busy           (busy),
        .done           (done),
        .falhas         (falhas),
        .primeira_falha (primeira_falha),
        .timeout_flag   (timeout_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // mode: 0 ideal decoder, 1 pass-through, 2 never acks, 3 ideal except n=7 uncorrected
    task automatic run_campaign(input logic [14:0] code, input int mode, input int lat,
                                input int pulse_at, input int reset_at, input bit hold);
        int          exp_falhas;
        int          exp_first;
        int          exp_edges;
        int          w;
        int          e0;
        bit          exp_to;
        logic [14:0] inj;
        logic [14:0] corr;
        logic [14:0] mask;
        exp_t        e;

        exp_falhas = 0;
        exp_first  = 31;
        exp_to     = (mode == 2);
        exp_edges  = (mode == 2) ? 16 * (TIMEOUT + 1) : 16 * (lat + 2);
        sb.delete();
        for (int p = 0; p < 16; p++) begin
            e.n    = (p < 15) ? 4'(p) : 4'd0;
            e.erro = (p < 15);
            e.word = code;
            sb.push_back(e);
            inj = (p < 15) ? (code ^ (15'd1 << p)) : code;
            case (mode)
                0:       corr = code;
                1:       corr = inj;
                3:       corr = (p == 7) ? inj : code;
                default: corr = ~code;
            endcase
            if (mode == 2 || corr != code) begin
                exp_falhas++;
                if (exp_first == 31) exp_first = p;
            end
        end

        @(negedge clk);
        codigo = code;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        codigo = ~code;
        e0 = cyc;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end

        for (int p = 0; p < 16; p++) begin
            w = 0;
            while (!req_dec && w < 4) begin
                @(posedge clk);
                #1;
                w++;
            end
            tests++;
            if (req_dec !== 1'b1 || w != ((p == 0 || hold) ? 0 : 1)) begin
                fails++;
                $display("FAIL req_rise pass %0d: req=%b after %0d edges want 1 after %0d",
                         p, req_dec, w, (p == 0 || hold) ? 0 : 1);
                sb.delete();
                return;
            end
            e = sb.pop_front();
            tests++;
            if ({n_inj, erro_inj, entrada_inj} !== {e.n, e.erro, e.word}) begin
                fails++;
                $display("FAIL inj_drive pass %0d: n=%0d erro=%b word=%h want n=%0d erro=%b word=%h",
                         p, n_inj, erro_inj, entrada_inj, e.n, e.erro, e.word);
            end

            if (p == reset_at) begin
                rst_n = 1'b0;
                #1;
                tests++;
                if ({entrada_inj, n_inj, erro_inj, req_dec, busy, done, falhas, primeira_falha, timeout_flag}
                    !== {15'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd31, 1'b0}) begin
                    fails++;
                    $display("FAIL async_reset: word=%h n=%0d erro=%b req=%b busy=%b done=%b falhas=%0d prim=%0d to=%b want all reset values",
                             entrada_inj, n_inj, erro_inj, req_dec, busy, done, falhas, primeira_falha, timeout_flag);
                end
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                w = 0;
                for (int k = 0; k < 4; k++) begin
                    @(posedge clk);
                    #1;
                    if (done || busy || req_dec) w++;
                end
                tests++;
                if (w != 0) begin
                    fails++;
                    $display("FAIL no_done_after_reset: activity seen in %0d cycles want 0", w);
                end
                $display("[TB] campaign code=%h aborted by reset at pass %0d", code, p);
                sb.delete();
                return;
            end

            if (mode == 2) begin
                w = 0;
                while (req_dec && w < TIMEOUT + 4) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                tests++;
                if (w != TIMEOUT) begin
                    fails++;
                    $display("FAIL timeout_len pass %0d: req high %0d cycles want %0d", p, w, TIMEOUT);
                end
            end else begin
                for (int k = 0; k < lat; k++) begin
                    @(posedge clk);
                    #1;
                end
                tests++;
                if (req_dec !== 1'b1 || n_inj !== e.n) begin
                    fails++;
                    $display("FAIL req_stable pass %0d: req=%b n=%0d want req=1 n=%0d", p, req_dec, n_inj, e.n);
                end
                mask = erro_inj ? (15'd1 << n_inj) : 15'd0;
                inj  = entrada_inj ^ mask;
                if (mode == 1 || (mode == 3 && erro_inj && n_inj == 4'd7)) corrigido = inj;
                else corrigido = inj ^ mask;
                ack_dec = 1'b1;
                if (p == pulse_at) start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                if (hold) begin
                    corrigido = ~code;
                    @(posedge clk);
                    #1;
                end
                ack_dec = 1'b0;
            end
        end

        w = 0;
        while (!done && w < 4) begin
            @(posedge clk);
            #1;
            w++;
        end
        tests++;
        if (done !== 1'b1 || (cyc - e0) != exp_edges) begin
            fails++;
            $display("FAIL done_timing: done=%b at E0+%0d want 1 at E0+%0d", done, cyc - e0 + 1, exp_edges + 1);
        end
        tests++;
        if (falhas !== 5'(exp_falhas) || primeira_falha !== 5'(exp_first) || timeout_flag !== exp_to) begin
            fails++;
            $display("FAIL stats: falhas=%0d prim=%0d to=%b want falhas=%0d prim=%0d to=%b",
                     falhas, primeira_falha, timeout_flag, exp_falhas, exp_first, exp_to);
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_in_fim: got %b want 1", busy);
        end
        @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL after_fim: done=%b busy=%b want 0 0", done, busy);
        end
        $display("[TB] campaign code=%h mode=%0d lat=%0d falhas=%0d primeira=%0d timeout=%b done@E0+%0d",
                 code, mode, lat, falhas, primeira_falha, timeout_flag, cyc - e0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        codigo = 15'h1234;
        ack_dec = 1'b0;
        corrigido = 15'd0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({entrada_inj, n_inj, erro_inj, req_dec, busy, done, falhas, primeira_falha, timeout_flag}
            !== {15'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd31, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: word=%h n=%0d erro=%b req=%b busy=%b done=%b falhas=%0d prim=%0d to=%b want reset values",
                     entrada_inj, n_inj, erro_inj, req_dec, busy, done, falhas, primeira_falha, timeout_flag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("[TB] reset checked");
    endtask

    task automatic test_ideal();
        run_campaign(15'h0000, 0, 0, -1, -1, 1'b0);
    endtask

    task automatic test_passthrough();
        run_campaign(15'h5A5A, 1, 0, -1, -1, 1'b0);
    endtask

    task automatic test_timeout();
        run_campaign(15'h3C3C, 2, 0, -1, -1, 1'b0);
    endtask

    task automatic test_miscorrect_7();
        run_campaign(15'h2B6D, 3, 3, -1, -1, 1'b0);
    endtask

    task automatic test_start_and_reset();
        run_campaign(15'h1F0E, 0, 0, 5, -1, 1'b0);
        run_campaign(15'h6A31, 1, 1, -1, 9, 1'b0);
        run_campaign(15'h4D55, 1, 2, -1, -1, 1'b0);
    endtask

    task automatic test_ack_outside();
        run_campaign(15'h7FFF, 0, 0, -1, -1, 1'b1);
        ack_dec = 1'b1;
        corrigido = 15'h0000;
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (falhas !== 5'd0 || primeira_falha !== 5'd31 || busy !== 1'b0 || req_dec !== 1'b0) begin
            fails++;
            $display("FAIL ack_in_idle: falhas=%0d prim=%0d busy=%b req=%b want 0 31 0 0",
                     falhas, primeira_falha, busy, req_dec);
        end
        ack_dec = 1'b0;
        $display("[TB] ack held in IDLE checked");
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_passthrough();
        test_timeout();
        test_miscorrect_7();
        test_start_and_reset();
        test_ack_outside();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
